// File: rtl/fetch_queue.sv
// fetch_queue: multi-lane in-order decoupling queue between fetch and decode, flushed by nuke_rb1.
// Optional same-cycle bypass through an empty queue when FETCH_QUEUE_BYPASS_EN is defined.
module fetch_queue #(
    parameter int DEPTH = 16,
    parameter int ENQ_W = 2,
    parameter int DEQ_W = 2,
    parameter int PKT_W = 64
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     nuke_rb1,
    input  logic [ENQ_W-1:0]         enq_valid_fe1,
    input  logic [ENQ_W*PKT_W-1:0]   enq_pkt_fe1,
    output logic                     enq_ready_fe1,
    output logic [DEQ_W-1:0]         deq_valid_de0,
    output logic [DEQ_W*PKT_W-1:0]   deq_pkt_de0,
    input  logic                     deq_ready_de0,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int BW = (DEQ_W < ENQ_W) ? DEQ_W : ENQ_W;

    logic [PKT_W-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr, wr_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    n_enq, n_out, n_skip, n_deq;
    logic             bypass;

    assign enq_ready_fe1 = count <= CW'(DEPTH - ENQ_W);
    assign occupancy     = count;

    always_comb begin
        n_enq = '0;
        for (int i = 0; i < ENQ_W; i++) n_enq = n_enq + CW'(enq_valid_fe1[i]);
        if (!enq_ready_fe1 || nuke_rb1) n_enq = '0;
        bypass = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
        bypass = (count == '0) && !nuke_rb1;
`endif
        for (int i = 0; i < DEQ_W; i++) begin
            deq_valid_de0[i]                 = !nuke_rb1 && (count > CW'(i));
            deq_pkt_de0[i*PKT_W +: PKT_W]    = mem[rd_ptr + AW'(i)];
        end
        // Empty queue: the oldest incoming lanes go straight to decode
        if (bypass) begin
            for (int i = 0; i < BW; i++) begin
                deq_valid_de0[i]              = CW'(i) < n_enq;
                deq_pkt_de0[i*PKT_W +: PKT_W] = enq_pkt_fe1[i*PKT_W +: PKT_W];
            end
        end
        n_out = '0;
        for (int i = 0; i < DEQ_W; i++) n_out = n_out + CW'(deq_valid_de0[i] & deq_ready_de0);
        n_skip = bypass ? n_out : '0;
        n_deq  = bypass ? '0 : n_out;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (nuke_rb1) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(n_enq - n_skip);
            rd_ptr <= rd_ptr + AW'(n_deq);
            count  <= count + n_enq - n_skip - n_deq;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < ENQ_W; i++)
            if (CW'(i) >= n_skip && CW'(i) < n_enq)
                mem[wr_ptr + AW'(i) - AW'(n_skip)] <= enq_pkt_fe1[i*PKT_W +: PKT_W];
    end

`ifdef ASSERT
    a_contig: assert property (@(posedge clk) disable iff (!reset_n)
        (enq_valid_fe1 & (enq_valid_fe1 + 1'b1)) == '0);
    a_bound: assert property (@(posedge clk) disable iff (!reset_n)
        (count <= CW'(DEPTH)) && ((CW+1)'(count) + (CW+1)'(n_enq) >= (CW+1)'(n_skip) + (CW+1)'(n_deq)));
    a_hold: assert property (@(posedge clk) disable iff (!reset_n)
        (!enq_ready_fe1 && !nuke_rb1) |=> (nuke_rb1 || $stable(enq_valid_fe1)));
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: randomized scoreboard bench for fetch_queue against a packet-queue reference model.
module tb_fetch_queue;
    localparam int DEPTH = 16, ENQ_W = 2, DEQ_W = 2, PKT_W = 64;
    localparam int CW = $clog2(DEPTH+1);

    logic clk = 0, reset_n = 0, nuke_rb1 = 0, deq_ready_de0 = 0;
    logic [ENQ_W-1:0]       enq_valid_fe1 = '0;
    logic [ENQ_W*PKT_W-1:0] enq_pkt_fe1 = '0;
    logic                   enq_ready_fe1;
    logic [DEQ_W-1:0]       deq_valid_de0;
    logic [DEQ_W*PKT_W-1:0] deq_pkt_de0;
    logic [CW-1:0]          occupancy;

    fetch_queue #(.DEPTH(DEPTH), .ENQ_W(ENQ_W), .DEQ_W(DEQ_W), .PKT_W(PKT_W)) dut (
        .clk(clk), .reset_n(reset_n), .nuke_rb1(nuke_rb1),
        .enq_valid_fe1(enq_valid_fe1), .enq_pkt_fe1(enq_pkt_fe1), .enq_ready_fe1(enq_ready_fe1),
        .deq_valid_de0(deq_valid_de0), .deq_pkt_de0(deq_pkt_de0), .deq_ready_de0(deq_ready_de0),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    logic [PKT_W-1:0] mq[$];
    int exp_cnt = 0, exp_push = 0, seq = 0;
    bit held = 0, mon_en = 0;

    task automatic chk(input string name, input logic [PKT_W-1:0] act, input logic [PKT_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // One clock of stimulus; refused groups are held until accepted or nuked.
    task automatic drive_cycle(input int nv, input bit rdy, input bit nk);
        @(posedge clk); #1;
        if (!held) begin
            enq_valid_fe1 = ENQ_W'((1 << nv) - 1);
            for (int i = 0; i < ENQ_W; i++) begin
                enq_pkt_fe1[i*PKT_W +: PKT_W] = (i < nv) ? {seq[31:0], 32'($urandom)} : '0;
                if (i < nv) seq++;
            end
        end
        nuke_rb1 = nk;
        deq_ready_de0 = rdy;
        exp_cnt = mq.size();
        exp_push = 0;
        if (!nk && DEPTH - exp_cnt >= ENQ_W)
            for (int i = 0; i < ENQ_W; i++)
                if (enq_valid_fe1[i]) begin
                    mq.push_back(enq_pkt_fe1[i*PKT_W +: PKT_W]);
                    exp_push++;
                end
        held = !nk && (DEPTH - exp_cnt < ENQ_W) && (enq_valid_fe1 != '0);
    endtask

    always @(negedge clk) begin : monitor
        int ev;
        if (mon_en && reset_n) begin
            ev = (exp_cnt < DEQ_W) ? exp_cnt : DEQ_W;
`ifdef FETCH_QUEUE_BYPASS_EN
            if (exp_cnt == 0) ev = (exp_push < DEQ_W) ? exp_push : DEQ_W;
`endif
            if (nuke_rb1) ev = 0;
            chk("deq_valid", PKT_W'(deq_valid_de0), PKT_W'((1 << ev) - 1));
            chk("occupancy", PKT_W'(occupancy), PKT_W'(exp_cnt));
            chk("enq_ready", PKT_W'(enq_ready_fe1), PKT_W'(DEPTH - exp_cnt >= ENQ_W));
            for (int i = 0; i < ev; i++) chk("deq_pkt", deq_pkt_de0[i*PKT_W +: PKT_W], mq[i]);
            if (nuke_rb1) mq.delete();
            else if (deq_ready_de0) repeat (ev) void'(mq.pop_front());
        end
    end

    initial begin
        #1;
        chk("rst_deq_valid", PKT_W'(deq_valid_de0), '0);
        chk("rst_enq_ready", PKT_W'(enq_ready_fe1), 1);
        chk("rst_occupancy", PKT_W'(occupancy), '0);
        #12 reset_n = 1;
        mon_en = 1;
        // {A,B} into an empty queue, then observe them held on deq
        drive_cycle(2, 0, 0);
        drive_cycle(0, 0, 0);
        drive_cycle(0, 1, 0);
        drive_cycle(0, 1, 0);
        // fill to DEPTH, a ninth group refused, then drain
        for (int k = 0; k < 9; k++) drive_cycle(2, 0, 0);
        drive_cycle(2, 0, 0);
        for (int k = 0; k < 12; k++) drive_cycle(0, 1, 0);
        // steady two-in/two-out stream wrapping the pointers
        for (int k = 0; k < 40; k++) drive_cycle(2, 1, 0);
        for (int k = 0; k < 3; k++) drive_cycle(0, 1, 0);
        // reach occupancy 9, nuke with a concurrent enqueue
        for (int k = 0; k < 4; k++) drive_cycle(2, 0, 0);
        drive_cycle(1, 0, 0);
        drive_cycle(2, 0, 1);
        for (int k = 0; k < 4; k++) drive_cycle(0, 1, 0);
        // randomized traffic with occasional nukes
        for (int k = 0; k < 600; k++)
            drive_cycle($urandom_range(0, ENQ_W), bit'($urandom_range(0, 1)), $urandom_range(0, 19) == 0);
        for (int k = 0; k < 12; k++) drive_cycle(0, 1, 0);
        // reach occupancy 5, then an asynchronous reset between edges
        drive_cycle(2, 0, 0);
        drive_cycle(2, 0, 0);
        drive_cycle(1, 0, 0);
        drive_cycle(0, 0, 0);
        chk("pre_reset_occupancy", PKT_W'(occupancy), 5);
        #1 reset_n = 0;
        enq_valid_fe1 = '0;
        held = 0;
        #1;
        chk("async_deq_valid", PKT_W'(deq_valid_de0), '0);
        chk("async_enq_ready", PKT_W'(enq_ready_fe1), 1);
        chk("async_occupancy", PKT_W'(occupancy), '0);
        mq.delete();
        exp_cnt = 0;
        exp_push = 0;
        @(posedge clk); #1 reset_n = 1;
        drive_cycle(2, 0, 0);
        drive_cycle(0, 1, 0);
        drive_cycle(0, 1, 0);
        @(posedge clk); #1;
        mon_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
